pool_patch_gen: RTL and testbench
=================================

Name: pool_patch_gen

Overview:
- Producer for the 2x2 max-pool datapath.
- Accepts a raster-order pixel stream (valid/ready), buffers one image line, and emits each non-overlapping 2x2 window as one packed PATCH word with a valid/ready handshake.
- PATCH connects directly to the pooling comparator's PATCH input; one patch is produced per two bottom-row pixels.

Parameters:
- DATAWIDTH, 16, unsigned pixel width in bits.
- IMG_W, 28, pixels per line; must be even and at least 2.
- IMG_H, 28, lines per frame; must be even and at least 2.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- IN_VALID  input  1  IN_PIXEL is valid.
- IN_READY  output  1  block can accept a pixel this cycle.
- IN_PIXEL  input  DATAWIDTH  raster pixel: row-major, column 0 first.
- OUT_VALID  output  1  PATCH/OUT_LAST valid.
- OUT_READY  input  1  downstream accepts the patch.
- PATCH  output  4*DATAWIDTH  packed window {top-left, top-right, bottom-left, bottom-right}; top-left in the MSBs.
- OUT_LAST  output  1  marks the final patch of a frame.

Behaviour:
- Handshakes:
  - Input beat when IN_VALID && IN_READY.
  - Output beat when OUT_VALID && OUT_READY.
  - IN_READY = !OUT_VALID || OUT_READY, combinational. Sustained throughput is one pixel per cycle.
- Counters:
  - col runs 0..IMG_W-1. row runs 0..IMG_H-1.
  - Both advance only on an input beat.
  - col wraps to 0 and row increments at IMG_W-1.
  - row wraps to 0 at the end of the frame (col=IMG_W-1, row=IMG_H-1); the next pixel starts a new frame.
- FSM with two states:
  - S_TOP (reset state): each input beat writes the pixel to line buffer address col. On the beat at col=IMG_W-1, go to S_BOT.
  - S_BOT, even col: capture the pixel into register bl.
  - S_BOT, odd col: load the output register with {LB[col-1], LB[col], bl, IN_PIXEL} and set OUT_VALID. OUT_LAST=1 iff row=IMG_H-1 and col=IMG_W-1.
  - S_BOT, beat at col=IMG_W-1: go to S_TOP.
- Latency: PATCH is valid the cycle after the bottom-right pixel's input beat.
- The line buffer is read at col-1 and col. Two reads are needed because the top pair must be available when the bottom-right pixel arrives; implement by registering the top-left word during the even-col bottom beat.
- Output register:
  - Holds PATCH, OUT_VALID and OUT_LAST stable while OUT_VALID && !OUT_READY.
  - Clears OUT_VALID on an output beat with no new load.
  - On a simultaneous drain and new load, the new patch replaces the old one; OUT_VALID stays 1.
- Backpressure: no pixel is accepted while the output register is full and not draining. This covers all states, even when the incoming pixel would not produce a patch; the simplicity is deliberate.
- Reset (any time, including mid-frame):
  - OUT_VALID=0, OUT_LAST=0, PATCH=0.
  - col=0, row=0, state=S_TOP, bl=0.
  - Line buffer contents are not cleared; they are don't-care until rewritten.
  - IN_READY=1 after reset.
- Arithmetic: pixels pass through unmodified; no sign interpretation. Counter widths are $clog2 of IMG_W and IMG_H, minimum 1.
- Patches per frame: (IMG_W/2)*(IMG_H/2), in raster order of the windows.

Decomposition:
- Shared package: DATAWIDTH default, PATCH slice index constants (TL=3, TR=2, BL=1, BR=0, slice i = [i*DATAWIDTH +: DATAWIDTH]), FSM state encodings S_TOP and S_BOT. The pooling comparator uses the same slice constants.
- One sub-module: pool_line_buf, an IMG_W x DATAWIDTH simple dual-port RAM with synchronous write and registered read, no reset, instantiated once.

Test Plan:
- IMG_W=4, IMG_H=2. Stream 1,2,3,4,5,6,7,8 with OUT_READY=1 -> PATCH=0x0001_0002_0005_0006 then 0x0003_0004_0007_0008; OUT_LAST only on the second; each one cycle after pixels 6 and 8 respectively.
- Same stream, OUT_READY=0 until 10 cycles after pixel 6 -> PATCH held stable at 0x0001_0002_0005_0006; IN_READY=0 from the cycle after pixel 6's beat; no pixel lost; second patch correct after release.
- IMG_W=4, IMG_H=4, two back-to-back frames of values 0..15 then 16..31 -> 8 patches total. The first is 0x0000_0001_0004_0005. The fifth is 0x0010_0011_0014_0015. OUT_LAST on the 4th and 8th.
- Assert rst after pixel 5 of a 4x2 frame, then stream 9..16 -> OUT_VALID=0 during reset; patches are 0x0009_000A_000D_000E and 0x000B_000C_000F_0010; no stale data appears.
- Pixels 0xFFFF and 0x8000 in all four positions, with random IN_VALID gaps -> bit-exact packing; patch count equals (W/2)*(H/2).
- OUT_READY toggling every cycle with IN_VALID=1 continuous -> no patch duplicated or dropped; the scoreboard matches the reference window extraction.

Source files
------------

// File: rtl/pool_patch_gen_pkg.sv
// Shared definitions for the 2x2 max-pool datapath.
//   - DATAWIDTH_DEF : default pixel width
//   - PATCH_*       : slice indices inside a packed PATCH word; slice i is
//                     PATCH[i*DATAWIDTH +: DATAWIDTH] (the comparator uses the same map)
//   - pool_state_e  : line-phase states of the patch generator
//   - cnt_width()   : counter width for a given range, never below one bit
package pool_patch_gen_pkg;

    localparam int DATAWIDTH_DEF = 16;

    localparam int PATCH_TL = 3;
    localparam int PATCH_TR = 2;
    localparam int PATCH_BL = 1;
    localparam int PATCH_BR = 0;

    typedef enum logic [0:0] {
        S_TOP = 1'b0,
        S_BOT = 1'b1
    } pool_state_e;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// One image line of pixel storage: simple dual-port RAM, synchronous write,
// registered read, no reset (contents are don't-care until written).
//   clk     : clock, rising edge
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address, sampled every cycle
//   rd_data : word at the address sampled on the previous edge
module pool_line_buf #(
    parameter int DATAWIDTH = 16,
    parameter int DEPTH     = 28,
    parameter int AW        = 5
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DATAWIDTH-1:0] wr_data,
    input  logic [AW-1:0]        rd_addr,
    output logic [DATAWIDTH-1:0] rd_data
);

    logic [DATAWIDTH-1:0] mem_r [DEPTH];
    logic [DATAWIDTH-1:0] rd_data_r;

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        rd_data_r <= mem_r[rd_addr];
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/pool_patch_gen.sv
// Producer for the 2x2 max-pool datapath. Takes a raster pixel stream,
// keeps the top line of each line pair in a line buffer and emits every
// non-overlapping 2x2 window as one packed PATCH word.
//   CLK       : clock, rising edge
//   rst       : asynchronous active-high reset
//   IN_VALID  : IN_PIXEL valid
//   IN_READY  : a pixel can be accepted this cycle
//   IN_PIXEL  : raster pixel, row-major, column 0 first
//   OUT_VALID : PATCH / OUT_LAST valid
//   OUT_READY : downstream accepts the patch
//   PATCH     : {top-left, top-right, bottom-left, bottom-right}, top-left in MSBs
//   OUT_LAST  : final patch of the frame
module pool_patch_gen
    import pool_patch_gen_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF,
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28
) (
    input  logic                   CLK,
    input  logic                   rst,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [DATAWIDTH-1:0]   IN_PIXEL,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [4*DATAWIDTH-1:0] PATCH,
    output logic                   OUT_LAST
);

    localparam int CW = cnt_width(IMG_W);
    localparam int RW = cnt_width(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    pool_state_e            state_r;
    logic [CW-1:0]          col_r;
    logic [RW-1:0]          row_r;
    logic [DATAWIDTH-1:0]   bl_r;
    logic [DATAWIDTH-1:0]   tl_r;
    logic [4*DATAWIDTH-1:0] patch_r;
    logic                   out_valid_r;
    logic                   out_last_r;

    logic                   in_ready_s;
    logic                   in_beat_s;
    logic                   load_s;
    logic                   lb_wr_en_s;
    logic [CW-1:0]          col_nxt_s;
    logic [RW-1:0]          row_nxt_s;
    logic [DATAWIDTH-1:0]   lb_rd_s;
    logic [4*DATAWIDTH-1:0] patch_nxt_s;

    // The whole block stalls while a patch is waiting, whatever the state.
    assign in_ready_s = !out_valid_r || OUT_READY;
    assign in_beat_s  = IN_VALID && in_ready_s;
    assign lb_wr_en_s = in_beat_s && (state_r == S_TOP);
    // Odd column of a bottom line completes a window.
    assign load_s     = in_beat_s && (state_r == S_BOT) && col_r[0];

    // Column/row counters for the next cycle
    always_comb begin
        col_nxt_s = col_r;
        row_nxt_s = row_r;
        if (in_beat_s) begin
            if (col_r == COL_LAST) begin
                col_nxt_s = {CW{1'b0}};
                if (row_r == ROW_LAST) begin
                    row_nxt_s = {RW{1'b0}};
                end else begin
                    row_nxt_s = row_r + RW'(1'b1);
                end
            end else begin
                col_nxt_s = col_r + CW'(1'b1);
            end
        end else begin
            col_nxt_s = col_r;
        end
    end

    // The read address is the column the counter will hold next cycle, so the
    // registered read data always reflects LB[col_r]. That gives the top-left
    // word on the even bottom beat (captured into tl_r) and the top-right word
    // on the odd bottom beat, even with back-to-back pixels.
    pool_line_buf #(
        .DATAWIDTH (DATAWIDTH),
        .DEPTH     (IMG_W),
        .AW        (CW)
    ) u_line_buf (
        .clk     (CLK),
        .wr_en   (lb_wr_en_s),
        .wr_addr (col_r),
        .wr_data (IN_PIXEL),
        .rd_addr (col_nxt_s),
        .rd_data (lb_rd_s)
    );

    // Assemble the window word from its four slices
    always_comb begin
        patch_nxt_s = {(4*DATAWIDTH){1'b0}};
        patch_nxt_s[PATCH_TL*DATAWIDTH +: DATAWIDTH] = tl_r;
        patch_nxt_s[PATCH_TR*DATAWIDTH +: DATAWIDTH] = lb_rd_s;
        patch_nxt_s[PATCH_BL*DATAWIDTH +: DATAWIDTH] = bl_r;
        patch_nxt_s[PATCH_BR*DATAWIDTH +: DATAWIDTH] = IN_PIXEL;
    end

    // Line-phase FSM with counters and the bottom-row holding registers
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_r <= S_TOP;
            col_r   <= {CW{1'b0}};
            row_r   <= {RW{1'b0}};
            bl_r    <= {DATAWIDTH{1'b0}};
            tl_r    <= {DATAWIDTH{1'b0}};
        end else begin
            col_r <= col_nxt_s;
            row_r <= row_nxt_s;
            case (state_r)
                S_TOP: begin
                    if (in_beat_s && (col_r == COL_LAST)) begin
                        state_r <= S_BOT;
                    end
                end
                S_BOT: begin
                    if (in_beat_s) begin
                        if (!col_r[0]) begin
                            bl_r <= IN_PIXEL;
                            tl_r <= lb_rd_s;
                        end
                        if (col_r == COL_LAST) begin
                            state_r <= S_TOP;
                        end
                    end
                end
                default: begin
                    state_r <= S_TOP;
                end
            endcase
        end
    end

    // Output holding register: load wins over drain, hold while stalled
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            patch_r     <= {(4*DATAWIDTH){1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else if (load_s) begin
            patch_r     <= patch_nxt_s;
            out_valid_r <= 1'b1;
            out_last_r  <= (row_r == ROW_LAST) && (col_r == COL_LAST);
        end else if (OUT_READY) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end
    end

    assign IN_READY  = in_ready_s;
    assign OUT_VALID = out_valid_r;
    assign PATCH     = patch_r;
    assign OUT_LAST  = out_last_r;

endmodule

// File: tb/tb_pool_patch_gen.sv
// Self-checking bench for pool_patch_gen: a 4x2 instance (dut_a) and a 4x4
// instance (dut_b). Monitors record every input and output beat; expected
// patches are extracted from the recorded input image with plain index
// arithmetic over 2x2 windows.
module tb_pool_patch_gen;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          sel;
    logic [DW-1:0] in_pixel;
    logic          out_ready;

    logic            in_valid_a, in_ready_a, out_valid_a, out_last_a;
    logic [4*DW-1:0] patch_a;
    logic            in_valid_b, in_ready_b, out_valid_b, out_last_b;
    logic [4*DW-1:0] patch_b;

    assign in_valid_a = in_valid & ~sel;
    assign in_valid_b = in_valid & sel;

    always #5 clk = ~clk;

    pool_patch_gen #(.DATAWIDTH(DW), .IMG_W(4), .IMG_H(2)) dut_a (
        .CLK(clk), .rst(rst), .IN_VALID(in_valid_a), .IN_READY(in_ready_a),
        .IN_PIXEL(in_pixel), .OUT_VALID(out_valid_a), .OUT_READY(out_ready),
        .PATCH(patch_a), .OUT_LAST(out_last_a));

    pool_patch_gen #(.DATAWIDTH(DW), .IMG_W(4), .IMG_H(4)) dut_b (
        .CLK(clk), .rst(rst), .IN_VALID(in_valid_b), .IN_READY(in_ready_b),
        .IN_PIXEL(in_pixel), .OUT_VALID(out_valid_b), .OUT_READY(out_ready),
        .PATCH(patch_b), .OUT_LAST(out_last_b));

    typedef struct {
        logic [4*DW-1:0] patch;
        logic            last;
        int              cyc;
    } obs_t;

    obs_t          oq_a[$], oq_b[$];
    logic [DW-1:0] pq_a[$], pq_b[$];
    int            pc_a[$], pc_b[$];
    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    int            rdy_mode = 0;  // 0 ready, 1 stalled, 2 toggle, 3 random

    always @(posedge clk) cyc <= cyc + 1;

    // Beats are sampled mid-cycle; they take effect at the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid_a && in_ready_a) begin pq_a.push_back(in_pixel); pc_a.push_back(cyc); end
            if (in_valid_b && in_ready_b) begin pq_b.push_back(in_pixel); pc_b.push_back(cyc); end
            if (out_valid_a && out_ready) oq_a.push_back('{patch_a, out_last_a, cyc});
            if (out_valid_b && out_ready) oq_b.push_back('{patch_b, out_last_b, cyc});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'b0;
            2: out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(1));
        endcase
    endtask

    task automatic send_pix(input logic [DW-1:0] v, input int gap_pct);
        bit done;
        int budget;
        while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) tick();
        in_valid = 1'b1;
        in_pixel = v;
        done = 1'b0;
        budget = 0;
        while (!done && budget < 200) begin
            @(negedge clk);
            done = sel ? in_ready_b : in_ready_a;
            tick();
            budget++;
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic clear_q();
        oq_a.delete(); oq_b.delete();
        pq_a.delete(); pq_b.delete();
        pc_a.delete(); pc_b.delete();
    endtask

    // Compare observed patches with windows cut from the recorded image.
    task automatic verify(input bit s, input int w, input int h, input string tag);
        logic [DW-1:0] px[$];
        obs_t          oq[$];
        int            nwin, n_exp, budget, n_obs;
        if (s) px = pq_b; else px = pq_a;
        nwin  = (w / 2) * (h / 2);
        n_exp = (px.size() / (w * h)) * nwin;
        budget = 0;
        n_obs = s ? oq_b.size() : oq_a.size();
        while (n_obs < n_exp && budget < 300) begin
            tick();
            budget++;
            n_obs = s ? oq_b.size() : oq_a.size();
        end
        repeat (4) tick();
        if (s) oq = oq_b; else oq = oq_a;
        check({tag, "_count"}, 64'(oq.size()), 64'(n_exp));
        for (int k = 0; k < n_exp && k < oq.size(); k++) begin
            int f, wi, wr, wc, base;
            logic [63:0] e;
            f    = k / nwin;
            wi   = k % nwin;
            wr   = wi / (w / 2);
            wc   = wi % (w / 2);
            base = f * w * h + 2 * wr * w + 2 * wc;
            e    = {px[base], px[base + 1], px[base + w], px[base + w + 1]};
            check($sformatf("%s_patch%0d", tag, k), oq[k].patch, e);
            check($sformatf("%s_last%0d", tag, k), 64'(oq[k].last), 64'(wi == nwin - 1));
        end
    endtask

    initial begin
        int hold_bad;
        logic [DW-1:0] v;
        rst = 1'b1; in_valid = 1'b0; sel = 1'b0; in_pixel = '0; out_ready = 1'b1;
        repeat (3) tick();

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid_a), 64'd0);
        check("rst_patch", patch_a, 64'd0);
        check("rst_out_last", 64'(out_last_a), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready_a", 64'(in_ready_a), 64'd1);
        check("rst_in_ready_b", 64'(in_ready_b), 64'd1);
        tick();

        // T1: 4x2 stream 1..8, downstream always ready
        clear_q(); rdy_mode = 0;
        for (int i = 1; i <= 8; i++) send_pix(DW'(i), 0);
        verify(1'b0, 4, 2, "t1");
        check("t1_p0", oq_a[0].patch, 64'h0001_0002_0005_0006);
        check("t1_p1", oq_a[1].patch, 64'h0003_0004_0007_0008);
        check("t1_last1", 64'(oq_a[1].last), 64'd1);
        check("t1_lat0", 64'(oq_a[0].cyc), 64'(pc_a[5] + 1));
        check("t1_lat1", 64'(oq_a[1].cyc), 64'(pc_a[7] + 1));

        // T2: same stream, downstream stalled for 10 cycles after pixel 6
        clear_q(); rdy_mode = 1; out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) send_pix(DW'(i), 0);
        in_valid = 1'b1; in_pixel = DW'(7);
        hold_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) check("t2_in_ready_low", 64'(in_ready_a), 64'd0);
            if (!(out_valid_a === 1'b1 && patch_a === 64'h0001_0002_0005_0006 &&
                  in_ready_a === 1'b0 && out_last_a === 1'b0)) hold_bad++;
            tick();
        end
        check("t2_hold", 64'(hold_bad), 64'd0);
        rdy_mode = 0; out_ready = 1'b1;
        send_pix(DW'(7), 0);
        send_pix(DW'(8), 0);
        verify(1'b0, 4, 2, "t2");
        check("t2_p1", oq_a[1].patch, 64'h0003_0004_0007_0008);

        // T3: 4x4, two back-to-back frames 0..31
        clear_q(); sel = 1'b1; rdy_mode = 0;
        for (int i = 0; i < 32; i++) send_pix(DW'(i), 0);
        verify(1'b1, 4, 4, "t3");
        check("t3_p0", oq_b[0].patch, 64'h0000_0001_0004_0005);
        check("t3_p4", oq_b[4].patch, 64'h0010_0011_0014_0015);
        check("t3_last3", 64'(oq_b[3].last), 64'd1);
        check("t3_last7", 64'(oq_b[7].last), 64'd1);

        // T4: reset after pixel 5 of a 4x2 frame, then stream 9..16
        sel = 1'b0;
        for (int i = 1; i <= 5; i++) send_pix(DW'(i), 0);
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("t4_valid_in_rst", 64'(out_valid_a), 64'd0);
        clear_q();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t4_in_ready", 64'(in_ready_a), 64'd1);
        tick();
        for (int i = 9; i <= 16; i++) send_pix(DW'(i), 0);
        verify(1'b0, 4, 2, "t4");
        check("t4_p0", oq_a[0].patch, 64'h0009_000A_000D_000E);
        check("t4_p1", oq_a[1].patch, 64'h000B_000C_000F_0010);

        // T5: extreme pixel values with input gaps and random backpressure
        clear_q(); rdy_mode = 3;
        for (int i = 0; i < 8; i++) send_pix((i % 3 == 0) ? 16'hFFFF : 16'h8000, 40);
        for (int i = 0; i < 8; i++) send_pix((i % 3 == 0) ? 16'h8000 : 16'hFFFF, 40);
        for (int i = 0; i < 16; i++) begin
            v = ($urandom_range(1) == 1) ? 16'hFFFF : 16'h8000;
            send_pix(v, 40);
        end
        verify(1'b0, 4, 2, "t5");

        // T6: 4x4, continuous input, downstream ready toggling every cycle
        clear_q(); sel = 1'b1; rdy_mode = 2;
        for (int i = 0; i < 32; i++) send_pix(DW'($urandom), 0);
        verify(1'b1, 4, 4, "t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
